pool_flat_engine: RTL

//  Layer-1/2 stage downstream of the conv/ReLU stage: reads layer-0 results (NUM_CH maps, IMG_W x IMG_W),

---
 rtl/pool_flat_engine_pkg.sv | 34 +++
 rtl/pool_flat_engine_if.sv | 24 ++
 rtl/pool_flat_engine_pool_addr_gen.sv | 59 +++++
 rtl/pool_flat_engine.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pool_flat_engine_pkg.sv
// Shared definitions for the pooling/flatten engine: conv-memory map select
// encodings, default widths and the FSM state type.
package pool_flat_engine_pkg;

  localparam int PFE_IMG_W  = 64;
  localparam int PFE_DATA_W = 20;
  localparam int PFE_NUM_CH = 2;
  localparam int PFE_ADDR_W = 12;

  localparam logic [2:0] CSEL_NONE  = 3'b000;
  localparam logic [2:0] CSEL_L0_K0 = 3'b001;
  localparam logic [2:0] CSEL_L0_K1 = 3'b010;
  localparam logic [2:0] CSEL_L1_K0 = 3'b011;
  localparam logic [2:0] CSEL_L1_K1 = 3'b100;
  localparam logic [2:0] CSEL_L2    = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_T,
    ST_WR_P,
    ST_WR_F,
    ST_DONE
  } pfe_state_t;

  function automatic logic [2:0] csel_l0(input logic ch);
    return ch ? CSEL_L0_K1 : CSEL_L0_K0;
  endfunction

  function automatic logic [2:0] csel_l1(input logic ch);
    return ch ? CSEL_L1_K1 : CSEL_L1_K0;
  endfunction

endpackage

// File: rtl/pool_flat_engine_if.sv
// Shared conv-memory port: one read channel (data returns one cycle after
// crd) and one write channel, both qualified by the csel map select.
interface pool_flat_engine_if #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 12
);
  logic              crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic [DATA_W-1:0] cdata_rd;
  logic              cwr;
  logic [ADDR_W-1:0] caddr_wr;
  logic [DATA_W-1:0] cdata_wr;
  logic [2:0]        csel;

  modport master (
    output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
    input  cdata_rd
  );

  modport slave (
    input  crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
    output cdata_rd
  );
endinterface

// File: rtl/pool_flat_engine_pool_addr_gen.sv
// Window/channel/sample counters and the address math for the pooling engine.
// Counters wrap back to zero after the last window of the last channel, so a
// completed pass leaves them ready for the next start.
module pool_addr_gen
  import pool_flat_engine_pkg::*;
#(
  parameter int IMG_W  = PFE_IMG_W,
  parameter int NUM_CH = PFE_NUM_CH,
  parameter int ADDR_W = PFE_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              smp_inc,
  input  logic              win_inc,
  output logic [1:0]        smp,
  output logic              ch,
  output logic              last,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] l1_addr,
  output logic [ADDR_W-1:0] l2_addr
);

  localparam int HALF_BITS = $clog2(IMG_W / 2);

  logic [HALF_BITS-1:0] wr;
  logic [HALF_BITS-1:0] wc;
  logic [1:0]           smp_q;
  logic                 ch_q;

  // Sample index steps per issued read; window index steps once per window,
  // rolling wc -> wr -> ch (map width is a power of two, so all-ones is last).
  always_ff @(posedge clk) begin
    if (reset) begin
      smp_q <= 2'd0;
      wr    <= '0;
      wc    <= '0;
      ch_q  <= 1'b0;
    end else begin
      if (smp_inc) smp_q <= smp_q + 2'd1;
      if (win_inc) begin
        wc <= wc + 1'b1;
        if (&wc) begin
          wr <= wr + 1'b1;
          if (&wr && (NUM_CH == 2)) ch_q <= ~ch_q;
        end
      end
    end
  end

  // Sample order inside a window: smp[1] selects the row, smp[0] the column,
  // and row*IMG_W+col reduces to a bit concatenation.
  assign rd_addr = ADDR_W'({wr, smp_q[1], wc, smp_q[0]});
  assign l1_addr = ADDR_W'({wr, wc});
  assign l2_addr = (NUM_CH == 2) ? ADDR_W'({wr, wc, ch_q}) : ADDR_W'({wr, wc});
  assign last    = (&wr) && (&wc) && (ch_q == 1'(NUM_CH - 1));
  assign smp     = smp_q;
  assign ch      = ch_q;

endmodule

// File: rtl/pool_flat_engine.sv
// 2x2 stride-2 max-pool over the layer-0 maps, writing each result to its
// layer-1 map and interleaved by channel into the layer-2 flatten map.
// Optional build macro PFE_CYCLE_CNT_EN adds a 16-bit busy-cycle counter port.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | waiting for start, memory port released
//  RD      | four reads of the current window (crd=1)
//  RD_T    | read tail: last sample arrives, max finalised
//  WR_P    | write max to the layer-1 map of the current channel
//  WR_F    | write max to the flatten map; next window or finish
//  DONE    | one-cycle done pulse
module pool_flat_engine
  import pool_flat_engine_pkg::*;
#(
  parameter int IMG_W  = PFE_IMG_W,
  parameter int DATA_W = PFE_DATA_W,
  parameter int NUM_CH = PFE_NUM_CH,
  parameter int ADDR_W = PFE_ADDR_W
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
`ifdef PFE_CYCLE_CNT_EN
  output logic [15:0] cycle_cnt,
`endif
  pool_flat_engine_if.master cmem
);

  pfe_state_t        state;
  logic [DATA_W-1:0] max_q;
  logic              last_q;
  logic              smp_inc;
  logic              win_inc;
  logic [1:0]        smp;
  logic              ch;
  logic              last;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] l1_addr;
  logic [ADDR_W-1:0] l2_addr;

  // Strictly greater replaces, so ties keep the earlier sample.
  function automatic logic [DATA_W-1:0] keep_max(input logic [DATA_W-1:0] cand,
                                                 input logic [DATA_W-1:0] cur);
    return ($signed(cand) > $signed(cur)) ? cand : cur;
  endfunction

  // A sample index is consumed every time a read address is registered.
  assign smp_inc = ((state == ST_IDLE) && start) ||
                   ((state == ST_RD) && (smp != 2'd0)) ||
                   ((state == ST_WR_F) && !last_q);
  // Advance during WR_P: the flatten address has already been sampled, and the
  // next window's first read address is ready by WR_F.
  assign win_inc = (state == ST_WR_P);

  pool_addr_gen #(
    .IMG_W (IMG_W),
    .NUM_CH(NUM_CH),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .smp_inc(smp_inc),
    .win_inc(win_inc),
    .smp    (smp),
    .ch     (ch),
    .last   (last),
    .rd_addr(rd_addr),
    .l1_addr(l1_addr),
    .l2_addr(l2_addr)
  );

  // Sequencer with registered memory-port outputs; read data lags crd by one
  // cycle, so samples land while smp is 2, 3, 0 and in RD_T.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      cmem.crd      <= 1'b0;
      cmem.cwr      <= 1'b0;
      cmem.caddr_rd <= '0;
      cmem.caddr_wr <= '0;
      cmem.cdata_wr <= '0;
      cmem.csel     <= CSEL_NONE;
      max_q         <= '0;
      last_q        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_RD;
            busy          <= 1'b1;
            cmem.crd      <= 1'b1;
            cmem.csel     <= csel_l0(ch);
            cmem.caddr_rd <= rd_addr;
          end
        end
        ST_RD: begin
          if (smp == 2'd2)      max_q <= cmem.cdata_rd;
          else if (smp != 2'd1) max_q <= keep_max(cmem.cdata_rd, max_q);
          if (smp == 2'd0) begin
            state     <= ST_RD_T;
            cmem.crd  <= 1'b0;
            cmem.csel <= CSEL_NONE;
          end else begin
            cmem.caddr_rd <= rd_addr;
          end
        end
        ST_RD_T: begin
          state         <= ST_WR_P;
          cmem.cwr      <= 1'b1;
          cmem.csel     <= csel_l1(ch);
          cmem.caddr_wr <= l1_addr;
          cmem.cdata_wr <= keep_max(cmem.cdata_rd, max_q);
        end
        ST_WR_P: begin
          state         <= ST_WR_F;
          cmem.csel     <= CSEL_L2;
          cmem.caddr_wr <= l2_addr;
          last_q        <= last;
        end
        ST_WR_F: begin
          cmem.cwr <= 1'b0;
          if (last_q) begin
            state     <= ST_DONE;
            cmem.csel <= CSEL_NONE;
            done      <= 1'b1;
          end else begin
            state         <= ST_RD;
            cmem.crd      <= 1'b1;
            cmem.csel     <= csel_l0(ch);
            cmem.caddr_rd <= rd_addr;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PFE_CYCLE_CNT_EN
  // Value always includes the current busy cycle: loads 1 for the first busy
  // cycle, so it reads the full busy length during the done cycle, then holds.
  always_ff @(posedge clk) begin
    if (reset)                          cycle_cnt <= 16'd0;
    else if ((state == ST_IDLE) && start) cycle_cnt <= 16'd1;
    else if (busy && (state != ST_DONE)) cycle_cnt <= cycle_cnt + 16'd1;
  end
`endif

endmodule
